// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud tick generator, frame FIFO with valid/ready head,
// overrun / frame-error status tracking and level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned IRQ_LEVEL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_en,
    input  logic [DIV_W-1:0]           baud_div,
    output logic                       baud_tick,
    input  logic [WIDTH-1:0]           core_data,
    input  logic                       core_ready,
    input  logic                       core_error,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_frame_err,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun,
    output logic [7:0]                 frame_err_cnt,
    input  logic                       clr_status,
    output logic                       irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Baud generator: the terminal value is latched at each wrap (and while
    // disabled), so a divisor change never strands the counter past its end.
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_term;
    logic [DIV_W-1:0] term_next;

    always_comb begin
        term_next = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    end

    assign baud_tick = rst_n && rx_en && (div_cnt == div_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            div_term <= '0;
        end else if (!rx_en || baud_tick) begin
            div_cnt  <= '0;
            div_term <= term_next;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            accept;
    logic            ovr_event;
    logic            err_event;
    logic [WIDTH:0]  head;

    assign m_valid   = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign push_req  = core_ready && rx_en;
    assign pop       = m_valid && m_ready;
    assign accept    = push_req && (!full || pop);
    assign ovr_event = push_req && full && !pop;
    assign err_event = accept && core_error;

    assign head        = mem[rd_ptr];
    assign m_data      = m_valid ? head[WIDTH-1:0] : '0;
    assign m_frame_err = m_valid && head[WIDTH];
    assign irq         = (level >= LW'(IRQ_LEVEL)) || overrun;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {core_error, core_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !accept) begin
                level <= level - LW'(1);
            end
        end
    end

    // A new event in the same cycle as clr_status takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun       <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            if (ovr_event) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (err_event) begin
                if (clr_status) begin
                    frame_err_cnt <= 8'd1;
                end else if (frame_err_cnt != 8'hFF) begin
                    frame_err_cnt <= frame_err_cnt + 8'd1;
                end
            end else if (clr_status) begin
                frame_err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames queue expected head words,
// a negedge monitor checks every accepted handshake.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic        baud_tick;
    logic [7:0]  core_data = '0;
    logic        core_ready = 1'b0;
    logic        core_error = 1'b0;
    logic [7:0]  m_data;
    logic        m_frame_err;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  level;
    logic        overrun;
    logic [7:0]  frame_err_cnt;
    logic        clr_status = 1'b0;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [8:0]  sb [$];

    uart_rx_ctrl #(.WIDTH(8), .DEPTH(8), .DIV_W(16), .IRQ_LEVEL(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_div(baud_div),
        .baud_tick(baud_tick), .core_data(core_data), .core_ready(core_ready),
        .core_error(core_error), .m_data(m_data), .m_frame_err(m_frame_err),
        .m_valid(m_valid), .m_ready(m_ready), .level(level), .overrun(overrun),
        .frame_err_cnt(frame_err_cnt), .clr_status(clr_status), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic e);
        core_data  = d;
        core_error = e;
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        core_error = 1'b0;
    endtask

    // Every handshake seen before the edge that pops it is matched to the queue head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {23'd0, m_frame_err, m_data}, 9'h1FF);
            end else begin
                logic [8:0] exp;
                exp = sb.pop_front();
                check("head_data", m_data, exp[7:0]);
                check("head_tag", m_frame_err, exp[8]);
            end
        end
    end

    initial begin
        int unsigned ticks;
        int unsigned first;

        // Reset state
        #2;
        check("rst_level", level, 0);
        check("rst_valid", m_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ferr", frame_err_cnt, 0);
        check("rst_tick", baud_tick, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // T1: divide by 4
        rx_en = 1'b1;
        #1;
        check("tick_at_enable", baud_tick, 0);
        ticks = 0;
        first = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (baud_tick) begin
                ticks++;
                if (first == 0) first = i;
            end
        end
        check("div4_ticks", ticks, 4);
        check("div4_first", first, 3);

        // baud_div=0 behaves as 1
        rx_en = 1'b0;
        baud_div = 16'd0;
        step();
        check("tick_disabled", baud_tick, 0);
        rx_en = 1'b1;
        #1;
        check("div0_immediate", baud_tick, 1);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (baud_tick) ticks++;
        end
        check("div0_ticks", ticks, 8);

        // Disable mid-count, counter restarts from 0
        rx_en = 1'b0;
        baud_div = 16'd4;
        step();
        rx_en = 1'b1;
        step();
        step();
        rx_en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (baud_tick) ticks++;
        end
        check("disabled_ticks", ticks, 0);
        rx_en = 1'b1;
        first = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (baud_tick && first == 0) first = i;
        end
        check("restart_first", first, 3);

        // T2: single frame through empty FIFO
        m_ready = 1'b1;
        check("pre_valid", m_valid, 0);
        sb.push_back({1'b0, 8'hA5});
        push_frame(8'hA5, 1'b0);
        check("t2_valid", m_valid, 1);
        check("t2_level", level, 1);
        step();
        check("t2_level_after", level, 0);
        check("t2_valid_after", m_valid, 0);
        m_ready = 1'b0;

        // T3: fill and overrun
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) sb.push_back({1'b0, 8'(i)});
            push_frame(8'(i), 1'b0);
            if (i == 3) check("irq_below", irq, 0);
            if (i == 4) check("irq_at_level", irq, 1);
            if (i == 8) check("full_no_ovr", overrun, 0);
        end
        check("t3_level", level, 8);
        check("t3_overrun", overrun, 1);
        check("t3_irq", irq, 1);
        check("t3_head", m_data, 8'h01);
        check("t3_head_tag", m_frame_err, 0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("clr_overrun", overrun, 0);
        check("clr_irq", irq, 1);
        clr_status = 1'b1;
        push_frame(8'h0B, 1'b0);
        clr_status = 1'b0;
        check("clr_vs_ovr", overrun, 1);
        check("clr_vs_ovr_level", level, 8);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("clr_again", overrun, 0);

        // T4: push and pop while full
        m_ready = 1'b1;
        sb.push_back({1'b0, 8'h0A});
        push_frame(8'h0A, 1'b0);
        m_ready = 1'b0;
        check("t4_level", level, 8);
        check("t4_overrun", overrun, 0);
        m_ready = 1'b1;
        repeat (8) step();
        m_ready = 1'b0;
        check("drain_level", level, 0);
        check("drain_valid", m_valid, 0);

        // T5: frame-error tagging and saturation
        m_ready = 1'b1;
        sb.push_back({1'b1, 8'h11});
        push_frame(8'h11, 1'b1);
        core_error = 1'b1;
        step();
        core_error = 1'b0;
        sb.push_back({1'b1, 8'h22});
        push_frame(8'h22, 1'b1);
        sb.push_back({1'b1, 8'h33});
        push_frame(8'h33, 1'b1);
        step();
        check("ferr_three", frame_err_cnt, 3);
        clr_status = 1'b1;
        sb.push_back({1'b1, 8'h44});
        push_frame(8'h44, 1'b1);
        clr_status = 1'b0;
        check("clr_vs_ferr", frame_err_cnt, 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("ferr_cleared", frame_err_cnt, 0);
        for (int i = 0; i < 260; i++) begin
            sb.push_back({1'b1, 8'(i)});
            push_frame(8'(i), 1'b1);
            if (i == 254) check("ferr_255", frame_err_cnt, 255);
        end
        check("ferr_sat", frame_err_cnt, 255);
        step();
        step();
        m_ready = 1'b0;
        check("t5_level", level, 0);

        // T6: reset with entries queued, then capture while disabled
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_frame(8'h50 + 8'(i), (i == 0));
        end
        check("t6_level_pre", level, 5);
        check("t6_ferr_pre", frame_err_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("t6_level", level, 0);
        check("t6_valid", m_valid, 0);
        check("t6_ferr", frame_err_cnt, 0);
        check("t6_overrun", overrun, 0);
        check("t6_irq", irq, 0);
        check("t6_data", m_data, 0);
        check("t6_tick", baud_tick, 0);
        step();
        rst_n = 1'b1;
        rx_en = 1'b0;
        step();
        push_frame(8'h77, 1'b1);
        step();
        check("dis_level", level, 0);
        check("dis_valid", m_valid, 0);
        check("dis_ferr", frame_err_cnt, 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
